// File: rtl/alu_rf_sequencer_pkg.sv
// Shared definitions for the ALU/register-file sequencer: FSM state
// encodings and the ALU opcode map used by the attached datapath.
package alu_rf_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    // Opcode map understood by the external ALU; the sequencer only forwards it.
    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_SUB    = 3'd1;
    localparam logic [2:0] OP_AND    = 3'd2;
    localparam logic [2:0] OP_OR     = 3'd3;
    localparam logic [2:0] OP_XOR    = 3'd4;
    localparam logic [2:0] OP_PASS_B = 3'd5;

endpackage

// File: rtl/alu_rf_sequencer_operand_sel.sv
// Operand-B selector: picks the immediate or the register read data,
// built bit by bit so it maps onto plain LUT muxes.
module alu_rf_sequencer_operand_sel #(
    parameter int DATA_W = 4
) (
    input  logic              use_imm,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] reg_data,
    output logic [DATA_W-1:0] operand
);

    // One 2:1 mux per data bit.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
        assign operand[gi] = use_imm ? imm[gi] : reg_data[gi];
    end

endmodule

// File: rtl/alu_rf_sequencer.sv
// Multi-cycle controller running one register-to-register ALU instruction
// at a time: IDLE (accept) -> READ (fetch operands) -> EXEC (drive ALU)
// -> WRITE (write back, pulse done) -> IDLE.
module alu_rf_sequencer
    import alu_rf_sequencer_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OP_W-1:0]   instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_rs1,
    input  logic [ADDR_W-1:0] instr_rs2,
    input  logic [DATA_W-1:0] instr_imm,
    input  logic              instr_use_imm,
    input  logic              instr_wb,
    output logic [ADDR_W-1:0] rf_raddr_a,
    output logic [ADDR_W-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_cout,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              result_cout
);

    state_t state_reg, state_next;

    // Instruction register
    logic [OP_W-1:0]   ir_op_reg;
    logic [ADDR_W-1:0] ir_rd_reg;
    logic [ADDR_W-1:0] ir_rs1_reg;
    logic [ADDR_W-1:0] ir_rs2_reg;
    logic [DATA_W-1:0] ir_imm_reg;
    logic              ir_use_imm_reg;
    logic              ir_wb_reg;

    // Operand and result registers
    logic [DATA_W-1:0] opa_reg;
    logic [DATA_W-1:0] opb_reg;
    logic [DATA_W-1:0] result_reg;
    logic              result_cout_reg;

    logic [DATA_W-1:0] opb_sel;
    logic              accept;

    assign accept = instr_valid && instr_ready;

    alu_rf_sequencer_operand_sel #(
        .DATA_W (DATA_W)
    ) u_operand_sel (
        .use_imm  (ir_use_imm_reg),
        .imm      (ir_imm_reg),
        .reg_data (rf_rdata_b),
        .operand  (opb_sel)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: fixed four-step ring, leaves IDLE only on a handshake
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept) state_next = ST_READ;
            ST_READ:  state_next = ST_EXEC;
            ST_EXEC:  state_next = ST_WRITE;
            ST_WRITE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Datapath registers: IR loads only on accept, operands in READ, result in EXEC
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_op_reg       <= '0;
            ir_rd_reg       <= '0;
            ir_rs1_reg      <= '0;
            ir_rs2_reg      <= '0;
            ir_imm_reg      <= '0;
            ir_use_imm_reg  <= 1'b0;
            ir_wb_reg       <= 1'b0;
            opa_reg         <= '0;
            opb_reg         <= '0;
            result_reg      <= '0;
            result_cout_reg <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && accept) begin
                ir_op_reg      <= instr_op;
                ir_rd_reg      <= instr_rd;
                ir_rs1_reg     <= instr_rs1;
                ir_rs2_reg     <= instr_rs2;
                ir_imm_reg     <= instr_imm;
                ir_use_imm_reg <= instr_use_imm;
                ir_wb_reg      <= instr_wb;
            end
            if (state_reg == ST_READ) begin
                opa_reg <= rf_rdata_a;
                opb_reg <= opb_sel;
            end
            if (state_reg == ST_EXEC) begin
                result_reg      <= alu_y;
                result_cout_reg <= alu_cout;
            end
        end
    end

    // Outputs: each bus is driven only in its own state and parked at 0 otherwise;
    // reset masks ready/we/done so an abandoned instruction never writes back
    always_comb begin
        instr_ready = 1'b0;
        rf_raddr_a  = '0;
        rf_raddr_b  = '0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        alu_op      = '0;
        alu_a       = '0;
        alu_b       = '0;
        done        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                instr_ready = !reset;
            end
            ST_READ: begin
                rf_raddr_a = ir_rs1_reg;
                rf_raddr_b = ir_rs2_reg;
            end
            ST_EXEC: begin
                alu_op = ir_op_reg;
                alu_a  = opa_reg;
                alu_b  = opb_reg;
            end
            ST_WRITE: begin
                rf_we    = ir_wb_reg && !reset;
                rf_waddr = ir_rd_reg;
                rf_wdata = result_reg;
                done     = !reset;
            end
            default: ;
        endcase
    end

    assign result      = result_reg;
    assign result_cout = result_cout_reg;

endmodule

// File: tb/tb_alu_rf_sequencer.sv
// Directed bench for alu_rf_sequencer: surrounds it with a register-file and
// ALU model, keeps a shadow register copy to predict write-backs, and checks
// every write-back against a scoreboard queue.
module tb_alu_rf_sequencer;
    import alu_rf_sequencer_pkg::*;

    logic       clk;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [2:0] instr_rd;
    logic [2:0] instr_rs1;
    logic [2:0] instr_rs2;
    logic [3:0] instr_imm;
    logic       instr_use_imm;
    logic       instr_wb;
    logic [2:0] rf_raddr_a;
    logic [2:0] rf_raddr_b;
    logic [3:0] rf_rdata_a;
    logic [3:0] rf_rdata_b;
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [3:0] rf_wdata;
    logic [2:0] alu_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_y;
    logic       alu_cout;
    logic       done;
    logic [3:0] result;
    logic       result_cout;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic       we;
        logic [2:0] waddr;
        logic [3:0] wdata;
        logic       cout;
    } sb_t;

    sb_t        sb[$];
    logic [3:0] sh[8];      // shadow of the register file contents
    logic [3:0] mem[8];     // register-file model
    logic       tb_we;
    logic [2:0] tb_waddr;
    logic [3:0] tb_wdata;

    alu_rf_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_op      (instr_op),
        .instr_rd      (instr_rd),
        .instr_rs1     (instr_rs1),
        .instr_rs2     (instr_rs2),
        .instr_imm     (instr_imm),
        .instr_use_imm (instr_use_imm),
        .instr_wb      (instr_wb),
        .rf_raddr_a    (rf_raddr_a),
        .rf_raddr_b    (rf_raddr_b),
        .rf_rdata_a    (rf_rdata_a),
        .rf_rdata_b    (rf_rdata_b),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .alu_op        (alu_op),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_y         (alu_y),
        .alu_cout      (alu_cout),
        .done          (done),
        .result        (result),
        .result_cout   (result_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU behaviour: {carry/borrow, y}
    function automatic logic [4:0] alu_ref(input logic [2:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
        case (op)
            OP_ADD:    return {1'b0, a} + {1'b0, b};
            OP_SUB:    return {1'b0, a} - {1'b0, b};
            OP_AND:    return {1'b0, a & b};
            OP_OR:     return {1'b0, a | b};
            OP_XOR:    return {1'b0, a ^ b};
            OP_PASS_B: return {1'b0, b};
            default:   return 5'd0;
        endcase
    endfunction

    assign {alu_cout, alu_y} = alu_ref(alu_op, alu_a, alu_b);
    assign rf_rdata_a = mem[rf_raddr_a];
    assign rf_rdata_b = mem[rf_raddr_b];

    // Register-file model: DUT write port, plus a bench port for preloading
    always @(posedge clk) begin
        if (rf_we) mem[rf_waddr] <= rf_wdata;
        else if (tb_we) mem[tb_waddr] <= tb_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rf_poke(input logic [2:0] a, input logic [3:0] d);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
        sh[a] = d;
    endtask

    // Predict the write-back and push it; returns operand values for the EXEC check
    task automatic predict(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                           input logic [2:0] rs2, input logic [3:0] imm, input logic use_imm,
                           input logic wb, output logic [3:0] a_exp, output logic [3:0] b_exp);
        logic [4:0] r;
        sb_t        e;
        a_exp = sh[rs1];
        b_exp = use_imm ? imm : sh[rs2];
        r = alu_ref(op, a_exp, b_exp);
        e.we = wb; e.waddr = rd; e.wdata = r[3:0]; e.cout = r[4];
        sb.push_back(e);
        if (wb) sh[rd] = r[3:0];
    endtask

    task automatic drive(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [3:0] imm, input logic use_imm,
                         input logic wb);
        instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
        instr_imm = imm; instr_use_imm = use_imm; instr_wb = wb;
    endtask

    // Compare the DUT's write-back cycle against the oldest scoreboard entry
    task automatic check_wb(input string tag);
        sb_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_we"}, rf_we, e.we);
            chk({tag, "_waddr"}, rf_waddr, e.we ? e.waddr : rf_waddr);
            chk({tag, "_wdata"}, rf_wdata, e.wdata);
            chk({tag, "_result"}, result, e.wdata);
            chk({tag, "_cout"}, result_cout, e.cout);
        end
    endtask

    // Issue one instruction from an IDLE negedge and follow it to completion
    task automatic run_instr(input string tag, input logic [2:0] op, input logic [2:0] rd,
                             input logic [2:0] rs1, input logic [2:0] rs2,
                             input logic [3:0] imm, input logic use_imm, input logic wb);
        logic [3:0] a_exp, b_exp;
        int lat;
        predict(op, rd, rs1, rs2, imm, use_imm, wb, a_exp, b_exp);
        chk({tag, "_ready_idle"}, instr_ready, 1);
        drive(op, rd, rs1, rs2, imm, use_imm, wb);
        instr_valid = 1'b1;
        lat = 0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            instr_valid = 1'b0;
            if (c == 1) begin
                chk({tag, "_raddr_a"}, rf_raddr_a, rs1);
                chk({tag, "_raddr_b"}, rf_raddr_b, rs2);
                chk({tag, "_ready_busy"}, instr_ready, 0);
            end
            if (c == 2) begin
                chk({tag, "_alu_op"}, alu_op, op);
                chk({tag, "_alu_a"}, alu_a, a_exp);
                chk({tag, "_alu_b"}, alu_b, b_exp);
            end
            if (done) lat = c;
        end
        chk({tag, "_latency"}, lat, 3);
        if (lat != 0) check_wb(tag);
        @(negedge clk);
        chk({tag, "_done_after"}, done, 0);
        chk({tag, "_we_after"}, rf_we, 0);
        chk({tag, "_ready_after"}, instr_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] a_exp, b_exp;
        logic [2:0] ops[3]  = '{OP_ADD, OP_XOR, OP_SUB};
        logic [2:0] rds[3]  = '{3'd5, 3'd6, 3'd7};
        logic [2:0] rs1s[3] = '{3'd1, 3'd5, 3'd6};
        logic [2:0] rs2s[3] = '{3'd4, 3'd0, 3'd5};
        logic [3:0] imms[3] = '{4'h0, 4'hA, 4'h0};
        logic       uses[3] = '{1'b0, 1'b1, 1'b0};
        int bad;

        reset = 1'b1; instr_valid = 1'b0; tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
        drive(3'd0, 3'd0, 3'd0, 3'd0, 4'd0, 1'b0, 1'b0);

        // 1: reset, then idle
        @(negedge clk);
        chk("rst_ready_low", instr_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", instr_ready, 1);
        chk("idle_done", done, 0);
        chk("idle_we", rf_we, 0);
        chk("idle_raddr", {rf_raddr_a, rf_raddr_b, rf_waddr}, 0);
        chk("idle_wdata", rf_wdata, 0);
        chk("idle_alu", {alu_op, alu_a, alu_b}, 0);
        chk("idle_result", {result_cout, result}, 0);

        for (int i = 0; i < 8; i++) rf_poke(i[2:0], i[3:0] + 4'h1);

        // 2: R2=5, R3=3, ADD r1 = r2 + r3
        rf_poke(3'd2, 4'h5);
        rf_poke(3'd3, 4'h3);
        run_instr("t2_add", OP_ADD, 3'd1, 3'd2, 3'd3, 4'h0, 1'b0, 1'b1);
        chk("t2_rf1", mem[1], 4'h8);

        // 3: R2=F, ADD r2 = r2 + imm 1 (wraps, carry set, rd == rs1)
        rf_poke(3'd2, 4'hF);
        run_instr("t3_addi", OP_ADD, 3'd2, 3'd2, 3'd0, 4'h1, 1'b1, 1'b1);
        chk("t3_rf2", mem[2], 4'h0);

        // 4: wb=0 SUB with borrow: result updates, register file untouched
        run_instr("t4_nowb", OP_SUB, 3'd4, 3'd2, 3'd3, 4'h0, 1'b0, 1'b0);
        chk("t4_rf4", mem[4], sh[4]);

        // rs1 == rs2 and PASS_B / AND coverage
        run_instr("t4b_and", OP_AND, 3'd0, 3'd6, 3'd6, 4'h0, 1'b0, 1'b1);
        run_instr("t4c_pass", OP_PASS_B, 3'd3, 3'd1, 3'd0, 4'hC, 1'b1, 1'b1);

        // 5: instr_valid held high; fields scrambled whenever the DUT is busy
        instr_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k % 4 == 0) begin
                chk($sformatf("t5_ready_k%0d", k), instr_ready, 1);
                predict(ops[k/4], rds[k/4], rs1s[k/4], rs2s[k/4], imms[k/4], uses[k/4],
                        1'b1, a_exp, b_exp);
                drive(ops[k/4], rds[k/4], rs1s[k/4], rs2s[k/4], imms[k/4], uses[k/4], 1'b1);
            end else begin
                chk($sformatf("t5_ready_k%0d", k), instr_ready, 0);
                drive(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                      4'($urandom), 1'($urandom), 1'($urandom));
            end
            if (k % 4 == 3) begin
                chk($sformatf("t5_done_k%0d", k), done, 1);
                check_wb($sformatf("t5_i%0d", k / 4));
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("t5_ready_end", instr_ready, 1);

        // 6: reset during EXEC abandons the instruction
        instr_valid = 1'b1;
        drive(OP_ADD, 3'd7, 3'd1, 3'd2, 4'h0, 1'b0, 1'b1);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("t6_in_exec", alu_op === OP_ADD && alu_a === sh[1], 1);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_ready", instr_ready, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_we", rf_we, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_ready_after", instr_ready, 1);
        chk("t6_result_cleared", {result_cout, result}, 0);
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            if (done !== 1'b0 || rf_we !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("t6_no_wb_pulse", bad, 0);
        chk("t6_rf7_kept", mem[7], sh[7]);

        // a normal instruction still works after the abort
        run_instr("t6_post", OP_OR, 3'd4, 3'd7, 3'd3, 4'h0, 1'b0, 1'b1);
        chk("t6_sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
